// File: rtl/control_pkg.sv
// Shared types and constants for the instruction control unit.
// Covers FSM states, opcode classes and the datapath control word.
package control_pkg;

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_EXEC  = 3'd1,
    S_MEM   = 3'd2,
    S_WB    = 3'd3,
    S_BR    = 3'd4,
    S_HALT  = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    OP_ALU_REG = 3'b000,
    OP_ALU_IMM = 3'b001,
    OP_LDW     = 3'b010,
    OP_STW     = 3'b011,
    OP_BCOND   = 3'b100,
    OP_BL      = 3'b101,
    OP_RET     = 3'b110,
    OP_SPECIAL = 3'b111
  } opclass_t;

  localparam logic [1:0] CC_ALWAYS = 2'b00;
  localparam logic [1:0] CC_ZERO   = 2'b01;
  localparam logic [1:0] CC_CARRY  = 2'b10;
  localparam logic [1:0] CC_NEG    = 2'b11;

  localparam logic [1:0] SUB_HALT = 2'b11;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 3;

  localparam logic [2:0] PC_SEQ    = 3'd0;
  localparam logic [2:0] PC_BRANCH = 3'd1;
  localparam logic [2:0] PC_LINK   = 3'd3;

  localparam logic [1:0] OP2_IMM = 2'd0;
  localparam logic [1:0] OP2_REG = 2'd1;
  localparam logic [1:0] RS_DEF  = 2'd0;
  localparam logic [1:0] RS_MEM  = 2'd1;
  localparam logic [1:0] ALU_ADD = 2'd0;

  typedef struct packed {
    logic       AluEn;
    logic [1:0] AluOR;
    logic       AluWe;
    logic       CFlag;
    logic       ImmSel;
    logic       IrWe;
    logic       LrEn;
    logic       LrSel;
    logic       LrWe;
    logic       MemEn;
    logic       Op1Sel;
    logic [1:0] Op2Sel;
    logic       PcEn;
    logic [2:0] PcSel;
    logic       PcWe;
    logic       RegWe;
    logic [1:0] Rs1Sel;
    logic [1:0] RwSel;
    logic       StatusRegEn;
    logic       WdSel;
  } ctrl_t;

  function automatic logic condTaken(
    input logic [1:0] cc,
    input logic       z,
    input logic       c,
    input logic       n
  );
    logic hit;
    case (cc)
      CC_ALWAYS: hit = 1'b1;
      CC_ZERO:   hit = z;
      CC_CARRY:  hit = c;
      CC_NEG:    hit = n;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational control-word decode from FSM state and the current IR.
// Everything is forced low until the sequencer has left reset.
module control_decode
  import control_pkg::*;
(
  input  logic [15:0] ir,
  input  state_t      state,
  input  logic        taken,
  input  logic        active,
  input  logic        nWait,
  output ctrl_t       ctrl,
  output logic        memRead,
  output logic        memWrite,
  output logic        halted
);

  opclass_t    opClass;
  logic [1:0]  subOp;
  logic [10:0] unusedIr;
  logic        isAlu;
  logic        isMem;
  logic        isLdw;
  logic        isStw;
  logic        isFlow;
  logic        isBl;
  logic        isRet;

  assign opClass  = opclass_t'(ir[15:13]);
  assign subOp    = ir[12:11];
  assign unusedIr = ir[10:0];

  assign isLdw  = opClass == OP_LDW;
  assign isStw  = opClass == OP_STW;
  assign isBl   = opClass == OP_BL;
  assign isRet  = opClass == OP_RET;
  assign isMem  = isLdw || isStw;
  assign isFlow = (opClass == OP_BCOND) || isBl;
  assign isAlu  = (opClass == OP_ALU_REG) ||
                  (opClass == OP_ALU_IMM);

  always_comb begin
    ctrl     = '0;
    memRead  = 1'b0;
    memWrite = 1'b0;
    halted   = 1'b0;
    if (active) begin
      unique case (state)
        S_FETCH: begin
          ctrl.MemEn = 1'b1;
          ctrl.PcSel = PC_SEQ;
          ctrl.IrWe  = nWait;
          ctrl.PcWe  = nWait;
          memRead    = 1'b1;
        end
        S_EXEC: begin
          unique case (1'b1)
            isAlu: begin
              ctrl.Op1Sel = 1'b0;
              ctrl.Op2Sel = (opClass == OP_ALU_REG) ?
                            OP2_REG : OP2_IMM;
              ctrl.AluOR  = subOp;
              ctrl.AluWe  = 1'b1;
            end
            isMem: begin
              ctrl.Op2Sel = OP2_IMM;
              ctrl.ImmSel = 1'b1;
              ctrl.AluOR  = ALU_ADD;
              ctrl.AluWe  = 1'b1;
              ctrl.Rs1Sel = RS_MEM;
              ctrl.RwSel  = RS_MEM;
            end
            isFlow: begin
              ctrl.Op1Sel = 1'b1;
              ctrl.Op2Sel = OP2_IMM;
              ctrl.ImmSel = 1'b0;
              ctrl.AluOR  = ALU_ADD;
              ctrl.AluWe  = 1'b1;
            end
            isRet: begin
              ctrl.PcWe  = 1'b1;
              ctrl.PcSel = PC_LINK;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          // ALU holds the address bus, so memory must not drive it
          ctrl.AluEn  = 1'b1;
          ctrl.Rs1Sel = RS_MEM;
          ctrl.RwSel  = RS_MEM;
          memRead     = isLdw;
          memWrite    = isStw;
        end
        S_WB: begin
          ctrl.RegWe  = 1'b1;
          ctrl.WdSel  = isLdw;
          ctrl.Rs1Sel = isLdw ? RS_MEM : RS_DEF;
          ctrl.RwSel  = isLdw ? RS_MEM : RS_DEF;
        end
        S_BR: begin
          ctrl.PcWe  = taken;
          ctrl.PcSel = PC_BRANCH;
          ctrl.LrWe  = taken && isBl;
          ctrl.LrSel = isBl;
        end
        S_HALT: halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle sequencer: fetch, execute, memory, writeback, branch, halt.
// Outputs are decoded from registered state and IR in control_decode.
module control_unit
  import control_pkg::*;
(
  input  logic        Clock,
  input  logic        nReset,
  input  logic [15:0] Ir,
  input  logic [3:0]  Flags,
  input  logic        nWait,
  output ctrl_t       Ctrl,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        Halted
);

  state_t      state;
  opclass_t    opClass;
  logic [1:0]  subOp;
  logic        active;
  logic        takenQ;
  logic        condHit;
  logic        unusedFlag;

  assign opClass    = opclass_t'(Ir[15:13]);
  assign subOp      = Ir[12:11];
  assign unusedFlag = Flags[FLAG_V];
  assign condHit    = condTaken(subOp,
                                Flags[FLAG_Z],
                                Flags[FLAG_C],
                                Flags[FLAG_N]);

  // active stays low for one edge so the first strobe follows release
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state  <= S_FETCH;
      active <= 1'b0;
      takenQ <= 1'b0;
    end else if (!active) begin
      active <= 1'b1;
    end else begin
      unique case (state)
        S_FETCH: begin
          if (nWait) state <= S_EXEC;
        end
        S_EXEC: begin
          takenQ <= (opClass == OP_BL) ||
                    ((opClass == OP_BCOND) && condHit);
          unique case (opClass)
            OP_ALU_REG,
            OP_ALU_IMM: state <= S_WB;
            OP_LDW,
            OP_STW:     state <= S_MEM;
            OP_BCOND:   state <= condHit ? S_BR : S_FETCH;
            OP_BL:      state <= S_BR;
            OP_RET:     state <= S_FETCH;
            OP_SPECIAL: state <= (subOp == SUB_HALT) ?
                                 S_HALT : S_FETCH;
            default:    state <= S_FETCH;
          endcase
        end
        S_MEM: begin
          if (nWait)
            state <= (opClass == OP_LDW) ? S_WB : S_FETCH;
        end
        S_WB:    state <= S_FETCH;
        S_BR:    state <= S_FETCH;
        S_HALT:  state <= S_HALT;
        default: state <= S_FETCH;
      endcase
    end
  end

  control_decode uDecode (
    .ir       (Ir),
    .state    (state),
    .taken    (takenQ),
    .active   (active),
    .nWait    (nWait),
    .ctrl     (Ctrl),
    .memRead  (MemRead),
    .memWrite (MemWrite),
    .halted   (Halted)
  );

  aOneDriver: assert property (
    @(posedge Clock) disable iff (!nReset)
    $countones({Ctrl.AluEn, Ctrl.MemEn, Ctrl.StatusRegEn}) <= 1
  );

  aRdWrExcl: assert property (
    @(posedge Clock) disable iff (!nReset)
    !(MemRead && MemWrite)
  );

endmodule

// File: tb/tb_control_unit.sv
// Directed and randomized checks of control_unit against a
// per-instruction cycle-schedule model.
module tb_control_unit;
  import control_pkg::*;

  typedef enum int {PH_F, PH_E, PH_M, PH_W, PH_B, PH_H} phase_t;

  typedef struct packed {
    ctrl_t c;
    logic  mr;
    logic  mw;
    logic  h;
  } obs_t;

  logic        Clock;
  logic        nReset;
  logic [15:0] Ir;
  logic [3:0]  Flags;
  logic        nWait;
  ctrl_t       Ctrl;
  logic        MemRead;
  logic        MemWrite;
  logic        Halted;

  int nCmp = 0;
  int nBad = 0;

  phase_t schedPh[$];
  logic   schedNw[$];

  control_unit dut (
    .Clock    (Clock),
    .nReset   (nReset),
    .Ir       (Ir),
    .Flags    (Flags),
    .nWait    (nWait),
    .Ctrl     (Ctrl),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .Halted   (Halted)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic isTaken(logic [1:0] cc, logic [3:0] fl);
    return (cc == 2'd0) || (cc == 2'd1 && fl[0]) ||
           (cc == 2'd2 && fl[1]) || (cc == 2'd3 && fl[3]);
  endfunction

  // Expected outputs for one cycle of an instruction's schedule
  function automatic obs_t model(phase_t ph, logic [15:0] ins, logic nw);
    obs_t       o;
    logic [2:0] cls;
    logic [1:0] sub;
    o   = '0;
    cls = ins[15:13];
    sub = ins[12:11];
    case (ph)
      PH_F: begin
        o.c.MemEn = 1'b1;
        o.mr      = 1'b1;
        o.c.IrWe  = nw;
        o.c.PcWe  = nw;
      end
      PH_E: begin
        if (cls <= 3'd1) begin
          o.c.Op2Sel = (cls == 3'd0) ? 2'd1 : 2'd0;
          o.c.AluOR  = sub;
          o.c.AluWe  = 1'b1;
        end else if (cls <= 3'd3) begin
          o.c.ImmSel = 1'b1;
          o.c.AluWe  = 1'b1;
          o.c.Rs1Sel = 2'd1;
          o.c.RwSel  = 2'd1;
        end else if (cls <= 3'd5) begin
          o.c.Op1Sel = 1'b1;
          o.c.AluWe  = 1'b1;
        end else if (cls == 3'd6) begin
          o.c.PcWe  = 1'b1;
          o.c.PcSel = 3'd3;
        end
      end
      PH_M: begin
        o.c.AluEn  = 1'b1;
        o.c.Rs1Sel = 2'd1;
        o.c.RwSel  = 2'd1;
        o.mr       = cls == 3'd2;
        o.mw       = cls == 3'd3;
      end
      PH_W: begin
        o.c.RegWe  = 1'b1;
        o.c.WdSel  = cls == 3'd2;
        o.c.Rs1Sel = (cls == 3'd2) ? 2'd1 : 2'd0;
        o.c.RwSel  = (cls == 3'd2) ? 2'd1 : 2'd0;
      end
      PH_B: begin
        o.c.PcWe  = 1'b1;
        o.c.PcSel = 3'd1;
        o.c.LrWe  = cls == 3'd5;
        o.c.LrSel = cls == 3'd5;
      end
      PH_H: o.h = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

  // Cycle-by-cycle phase list for one instruction with given stalls
  task automatic buildSched(input logic [15:0] ins, input int wf,
                            input int wm, input logic [3:0] fl);
    logic [2:0] cls;
    cls = ins[15:13];
    schedPh.delete();
    schedNw.delete();
    for (int i = 0; i <= wf; i++) begin
      schedPh.push_back(PH_F);
      schedNw.push_back(i == wf);
    end
    schedPh.push_back(PH_E);
    schedNw.push_back(1'($urandom));
    if (cls == 3'd2 || cls == 3'd3) begin
      for (int i = 0; i <= wm; i++) begin
        schedPh.push_back(PH_M);
        schedNw.push_back(i == wm);
      end
    end
    if (cls <= 3'd2) begin
      schedPh.push_back(PH_W);
      schedNw.push_back(1'($urandom));
    end
    if ((cls == 3'd4 && isTaken(ins[12:11], fl)) || cls == 3'd5) begin
      schedPh.push_back(PH_B);
      schedNw.push_back(1'($urandom));
    end
    if (cls == 3'd7 && ins[12:11] == 2'b11) begin
      schedPh.push_back(PH_H);
      schedNw.push_back(1'($urandom));
    end
  endtask

  // Drive at posedge+1, sample at the following negedge
  task automatic step(input logic [15:0] ins, input logic nw,
                      input logic [3:0] fl, output obs_t got);
    Ir    = ins;
    nWait = nw;
    Flags = fl;
    @(negedge Clock);
    got.c  = Ctrl;
    got.mr = MemRead;
    got.mw = MemWrite;
    got.h  = Halted;
    @(posedge Clock);
    #1;
  endtask

  task automatic releaseReset();
    nReset = 1'b1;
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    obs_t got;
    nReset = 1'b0;
    Ir     = 16'h0004;
    nWait  = 1'b1;
    Flags  = 4'hF;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    got = {Ctrl, MemRead, MemWrite, Halted};
    nCmp++;
    if (got !== '0) begin
      nBad++;
      $display("FAIL reset_hold: got %h, expected 0", got);
    end
    @(posedge Clock);
    #1;
    nReset = 1'b1;
    @(negedge Clock);
    got = {Ctrl, MemRead, MemWrite, Halted};
    nCmp++;
    if (got !== '0) begin
      nBad++;
      $display("FAIL reset_release_pre_edge: got %h, expected 0", got);
    end
    @(posedge Clock);
    #1;
    nCmp++;
    if ({MemRead, Ctrl.MemEn, Ctrl.IrWe} !== 3'b111) begin
      nBad++;
      $display("FAIL first_fetch: got %b, expected 111",
               {MemRead, Ctrl.MemEn, Ctrl.IrWe});
    end
  endtask

  task automatic test_alu();
    logic [15:0] insTab[2];
    int          wfTab[2];
    obs_t        got, exp;
    logic [3:0]  fl;
    insTab = '{16'h0004, 16'h2A55};
    wfTab  = '{0, 2};
    for (int t = 0; t < 2; t++) begin
      fl = 4'($urandom);
      buildSched(insTab[t], wfTab[t], 0, fl);
      foreach (schedPh[i]) begin
        step(insTab[t], schedNw[i],
             (schedPh[i] == PH_E) ? fl : 4'($urandom), got);
        exp = model(schedPh[i], insTab[t], schedNw[i]);
        nCmp++;
        if (got !== exp) begin
          nBad++;
          $display("FAIL alu ins=%h cyc%0d: got %h, expected %h",
                   insTab[t], i, got, exp);
        end
      end
    end
  endtask

  task automatic test_mem();
    logic [15:0] insTab[3];
    int          wmTab[3];
    obs_t        got, exp;
    insTab = '{16'h4123, 16'h6321, 16'h4000};
    wmTab  = '{2, 1, 0};
    for (int t = 0; t < 3; t++) begin
      buildSched(insTab[t], 1, wmTab[t], 4'h0);
      foreach (schedPh[i]) begin
        step(insTab[t], schedNw[i], 4'($urandom), got);
        exp = model(schedPh[i], insTab[t], schedNw[i]);
        nCmp++;
        if (got !== exp) begin
          nBad++;
          $display("FAIL mem ins=%h cyc%0d: got %h, expected %h",
                   insTab[t], i, got, exp);
        end
      end
    end
  endtask

  task automatic test_bcond();
    logic [15:0] insTab[8];
    logic [3:0]  flTab[8];
    obs_t        got, exp;
    insTab = '{16'h8800, 16'h8800, 16'h8800, 16'h9000,
               16'h9000, 16'h9800, 16'h9800, 16'h8000};
    flTab  = '{4'b0001, 4'b0000, 4'b1110, 4'b0010,
               4'b1101, 4'b1000, 4'b0111, 4'b0000};
    for (int t = 0; t < 8; t++) begin
      buildSched(insTab[t], 0, 0, flTab[t]);
      foreach (schedPh[i]) begin
        step(insTab[t], schedNw[i],
             (schedPh[i] == PH_E) ? flTab[t] : 4'($urandom), got);
        exp = model(schedPh[i], insTab[t], schedNw[i]);
        nCmp++;
        if (got !== exp) begin
          nBad++;
          $display("FAIL bcond ins=%h fl=%b cyc%0d: got %h, expected %h",
                   insTab[t], flTab[t], i, got, exp);
        end
      end
    end
  endtask

  task automatic test_bl_ret();
    logic [15:0] insTab[4];
    obs_t        got, exp;
    insTab = '{16'hA000, 16'hC000, 16'hE000, 16'hF000};
    for (int t = 0; t < 4; t++) begin
      buildSched(insTab[t], 0, 0, 4'h0);
      foreach (schedPh[i]) begin
        step(insTab[t], schedNw[i], 4'($urandom), got);
        exp = model(schedPh[i], insTab[t], schedNw[i]);
        nCmp++;
        if (got !== exp) begin
          nBad++;
          $display("FAIL bl_ret ins=%h cyc%0d: got %h, expected %h",
                   insTab[t], i, got, exp);
        end
      end
    end
  endtask

  task automatic test_halt();
    obs_t got, exp;
    buildSched(16'hF800, 0, 0, 4'h0);
    for (int i = 0; i < 11; i++) begin
      schedPh.push_back(PH_H);
      schedNw.push_back(1'($urandom));
    end
    foreach (schedPh[i]) begin
      step(16'hF800, schedNw[i], 4'($urandom), got);
      exp = model(schedPh[i], 16'hF800, schedNw[i]);
      nCmp++;
      if (got !== exp) begin
        nBad++;
        $display("FAIL halt cyc%0d: got %h, expected %h", i, got, exp);
      end
    end
    nReset = 1'b0;
    #1;
    got = {Ctrl, MemRead, MemWrite, Halted};
    nCmp++;
    if (got !== '0) begin
      nBad++;
      $display("FAIL halt_reset: got %h, expected 0", got);
    end
    @(posedge Clock);
    #1;
    releaseReset();
    buildSched(16'h0004, 0, 0, 4'h0);
    foreach (schedPh[i]) begin
      step(16'h0004, schedNw[i], 4'($urandom), got);
      exp = model(schedPh[i], 16'h0004, schedNw[i]);
      nCmp++;
      if (got !== exp) begin
        nBad++;
        $display("FAIL halt_resume cyc%0d: got %h, expected %h",
                 i, got, exp);
      end
    end
  endtask

  task automatic test_async_reset();
    obs_t got, exp;
    step(16'h6000, 1'b1, 4'h0, got);
    step(16'h6000, 1'b0, 4'h0, got);
    nWait = 1'b0;
    @(negedge Clock);
    got = {Ctrl, MemRead, MemWrite, Halted};
    exp = model(PH_M, 16'h6000, 1'b0);
    nCmp++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL stw_mem: got %h, expected %h", got, exp);
    end
    #2;
    nReset = 1'b0;
    #1;
    got = {Ctrl, MemRead, MemWrite, Halted};
    nCmp++;
    if (got !== '0) begin
      nBad++;
      $display("FAIL async_reset: got %h, expected 0", got);
    end
    @(posedge Clock);
    #1;
    releaseReset();
  endtask

  task automatic test_random();
    logic [2:0]  cls;
    logic [1:0]  sub;
    logic [31:0] r;
    logic [15:0] ins;
    logic [3:0]  fl;
    obs_t        got, exp;
    for (int n = 0; n < 150; n++) begin
      cls = 3'($urandom_range(0, 7));
      sub = 2'($urandom_range(0, 3));
      if (cls == 3'd7 && sub == 2'd3) sub = 2'd2;
      r   = $urandom;
      ins = {cls, sub, r[10:0]};
      fl  = 4'($urandom);
      buildSched(ins, $urandom_range(0, 2), $urandom_range(0, 2), fl);
      foreach (schedPh[i]) begin
        step(ins, schedNw[i],
             (schedPh[i] == PH_E) ? fl : 4'($urandom), got);
        exp = model(schedPh[i], ins, schedNw[i]);
        nCmp++;
        if (got !== exp) begin
          nBad++;
          $display("FAIL random n=%0d ins=%h cyc%0d: got %h, expected %h",
                   n, ins, i, got, exp);
        end
      end
    end
  endtask

  initial begin
    nReset = 1'b0;
    Ir     = '0;
    Flags  = '0;
    nWait  = 1'b1;
    test_reset();
    test_alu();
    test_mem();
    test_bcond();
    test_bl_ret();
    test_halt();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Clock  input  1  single clock; all state changes on rising edge.
REQ-002 nReset  input  1  asynchronous, active-low reset.
REQ-003 Ir  input  16  current instruction from datapath IR; opcode class Ir[15:13], sub-field Ir[12:11].
REQ-004 Flags  input  4  ALU flags {N,V,C,Z} = Flags[3:0]; Z=Flags[0], C=Flags[1], N=Flags[3].
REQ-005 nWait  input  1  memory not ready when low; stalls FETCH and MEM states.
REQ-006 Ctrl  output  ctrl_t  packed datapath control word; fields listed in REQ-030.
REQ-007 MemRead  output  1  memory read strobe, active high.
REQ-008 MemWrite  output  1  memory write strobe, active high.
REQ-009 Halted  output  1  high while in HALT state.

Function
REQ-010 States SHALL be FETCH, EXEC, MEM, WB, BR, HALT; every non-HALT instruction begins in FETCH.
REQ-011 Classes: 000 ALU-reg, 001 ALU-imm, 010 LDW, 011 STW, 100 Bcond, 101 BL, 110 RET, 111 special (Ir[12:11]=11 HALT, otherwise NOP).
REQ-012 FETCH: MemEn=1, MemRead=1, PcSel=0; while nWait=1, IrWe=1, PcWe=1 and next state EXEC; while nWait=0, IrWe=PcWe=0 and remain in FETCH.
REQ-013 EXEC ALU-reg/ALU-imm: Op1Sel=0, Op2Sel=1 (reg) or 0 (imm), AluOR=Ir[12:11], AluWe=1 -> WB.
REQ-014 WB ALU: RegWe=1, WdSel=0 -> FETCH; an ALU instruction takes exactly 3 cycles with nWait=1.
REQ-015 EXEC LDW/STW: address = Rd1+Imm (ImmSel=1), AluWe=1 -> MEM.
REQ-016 MEM: AluEn=1; LDW MemRead=1, STW MemWrite=1; hold all outputs while nWait=0; on nWait=1, LDW -> WB (WdSel=1, RegWe=1), STW -> FETCH.
REQ-017 Condition taken = (Ir[12:11]==00) | (01 & Z) | (10 & C) | (11 & N), sampled from Flags during EXEC.
REQ-018 EXEC Bcond/BL: Op1Sel=1 (Pc), Op2Sel=0, ImmSel=0, AluOR=0 (add), AluWe=1; taken -> BR, not taken -> FETCH; BL is always taken.
REQ-019 BR: PcWe=1, PcSel=1; BL additionally LrWe=1, LrSel=1 in the same cycle -> FETCH.
REQ-020 EXEC RET: PcWe=1, PcSel=3 -> FETCH; EXEC NOP -> FETCH with no write enables asserted.
REQ-021 EXEC HALT -> HALT; HALT is sticky, asserts Halted=1 and all enables 0, and is left only by reset.
REQ-022 At most one of AluEn, MemEn, StatusRegEn SHALL be high in any cycle (single bus driver).
REQ-023 MemRead and MemWrite SHALL never be high together.
REQ-024 All outputs SHALL be decoded from registered state and Ir (Moore style, plus the FETCH/MEM nWait qualifier); no output depends on Flags except next-state.
REQ-025 Unused Ctrl fields (CFlag, LrEn, PcEn, Rs1Sel, RwSel, StatusRegEn) SHALL be 0 except where stated; Rs1Sel/RwSel = 1 for LDW/STW, 0 otherwise.

Reset
REQ-026 nReset low SHALL immediately force state FETCH and all Ctrl fields, MemRead, MemWrite and Halted to 0, including mid-instruction or in HALT.
REQ-027 The first FETCH strobe SHALL assert on the first rising edge after nReset deasserts.

Structure
REQ-028 Package control_pkg SHALL hold state_t enum, opclass_t enum, ctrl_t struct and the condition-code constants.
REQ-029 A combinational sub-module control_decode (Ir, state, taken -> ctrl_t) SHALL be instantiated inside control_unit; next-state logic stays in control_unit.
REQ-030 ctrl_t SHALL contain AluEn, AluOR[1:0], AluWe, CFlag, ImmSel, IrWe, LrEn, LrSel, LrWe, MemEn, Op1Sel, Op2Sel[1:0], PcEn, PcSel[2:0], PcWe, RegWe, Rs1Sel[1:0], RwSel[1:0], StatusRegEn, WdSel.

Verification
REQ-031 Ir=16'h0004 (ALU-reg) with nWait=1 -> FETCH, EXEC, WB; RegWe=1 only in cycle 3; FETCH again in cycle 4.
REQ-032 LDW (Ir[15:13]=010) with nWait=0 for 2 MEM cycles -> MEM held 3 cycles with MemRead=1 and AluEn=1, then WB with WdSel=1, RegWe=1.
REQ-033 Bcond on Z (Ir[15:11]=10001): Flags=4'b0001 -> BR with PcWe=1, PcSel=1; Flags=4'b0000 -> EXEC then FETCH, PcWe=0.
REQ-034 BL (Ir[15:13]=101) -> BR cycle with PcWe=1, LrWe=1, LrSel=1; RET (110) -> EXEC with PcSel=3, PcWe=1.
REQ-035 Ir=16'hF800 (HALT) -> Halted=1 for 10+ cycles with all enables 0; nReset pulse low -> Halted=0 and FETCH resumes.
REQ-036 nReset asserted during MEM of STW -> MemWrite drops to 0 asynchronously, without waiting for a clock edge.
